// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered status flags.
// Flags and occupancy are computed from the next count, so they always
// agree with fifo_count in the same cycle. There is no bypass from the
// write port to the read port; a pushed word is readable one cycle later.
module fifo #(
    parameter int DATA_WIDTH      = 64,
    parameter     INIT            = "init.mif",
    parameter int ADDR_WIDTH      = 4,
    parameter int RAM_DEPTH       = 1 << ADDR_WIDTH,
    parameter     INITIALIZE_FIFO = "no",
    parameter     TYPE            = "MLAB"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_count
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(RAM_DEPTH - 4);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance, pointer advance, next occupancy and flags derived from it.
    always_comb begin
        // A pop needs something stored; a push needs room, which a
        // simultaneous pop on a full FIFO provides.
        pop_ok  = pop && !empty_q;
        push_ok = push && (!full_q || pop);
        wp_d    = push_ok ? wp_q + PTR_ONE : wp_q;
        rp_d    = pop_ok  ? rp_q + PTR_ONE : rp_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
        afull_d = (count_d >= CNT_AFULL);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    // Storage: two variants differing only in the preload attribute, so the
    // vendor tool sees the init file only when preloading is requested.
    // Contents survive reset; only the output register is cleared.
    generate
        if (INITIALIZE_FIFO == "yes") begin : g_mem_init
            (* ramstyle = TYPE, ram_init_file = INIT *)
            logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

            // Write port.
            always_ff @(posedge clk) begin
                if (push_ok && reset) begin
                    mem[wp_q] <= data_in;
                end
            end

            // Registered read port; old data is returned when full and the
            // write lands on the same address as the read.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_out_q <= '0;
                end else if (pop_ok) begin
                    data_out_q <= mem[rp_q];
                end
            end
        end else begin : g_mem_plain
            (* ramstyle = TYPE *)
            logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

            // Write port.
            always_ff @(posedge clk) begin
                if (push_ok && reset) begin
                    mem[wp_q] <= data_in;
                end
            end

            // Registered read port; old data is returned when full and the
            // write lands on the same address as the read.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_out_q <= '0;
                end else if (pop_ok) begin
                    data_out_q <= mem[rp_q];
                end
            end
        end
    endgenerate

    assign data_out    = data_out_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the FIFO.
module tb_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   fifo_count;

    fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: contents in arrival order plus the last word read.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare every output.
    task automatic step(input logic rst_n, input logic p, input logic q, input logic [DW-1:0] d);
        bit pop_acc;
        bit push_acc;
        reset   = rst_n;
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            pop_acc  = q && (model_q.size() > 0);
            push_acc = p && ((model_q.size() < DEPTH) || pop_acc);
            if (pop_acc)  model_dout = model_q.pop_front();
            if (push_acc) model_q.push_back(d);
        end
        $display("cyc %0d rst_n=%0b push=%0b pop=%0b din=%08h -> dout=%08h cnt=%0d e=%0b f=%0b af=%0b",
                 cyc, rst_n, p, q, d, data_out, fifo_count, empty, full, almost_full);
        check("count", 64'(fifo_count), 64'(model_q.size()));
        check("empty", 64'(empty), 64'(model_q.size() == 0));
        check("full", 64'(full), 64'(model_q.size() == DEPTH));
        check("almost_full", 64'(almost_full), 64'(model_q.size() >= DEPTH - 4));
        check("data_out", 64'(data_out), 64'(model_dout));
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        model_dout = '0;

        // Reset then single transfer.
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 32'h1234);
        check("single_cnt_after_push", 64'(fifo_count), 64'd1);
        step(1'b1, 1'b0, 1'b1, '0);
        check("single_dout", 64'(data_out), 64'h1234);
        check("single_empty", 64'(empty), 64'd1);

        // Fill, rejected 17th push, drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, DW'(i));
            if (i == 10) check("af_below_12", 64'(almost_full), 64'd0);
            if (i == 11) check("af_at_12", 64'(almost_full), 64'd1);
        end
        check("fill_full", 64'(full), 64'd1);
        step(1'b1, 1'b1, 1'b0, 32'hFF);
        check("push_when_full_cnt", 64'(fifo_count), 64'd16);

        // Simultaneous push/pop while full: oldest out, new word at tail.
        step(1'b1, 1'b1, 1'b1, 32'hBEEF);
        check("full_pp_dout", 64'(data_out), 64'h0);
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check("drain_order", 64'(data_out), 64'(i));
        end
        step(1'b1, 1'b0, 1'b1, '0);
        check("tail_word", 64'(data_out), 64'hBEEF);

        // Pop on empty, then simultaneous push/pop on empty.
        step(1'b1, 1'b0, 1'b1, '0);
        check("pop_empty_dout", 64'(data_out), 64'hBEEF);
        step(1'b1, 1'b1, 1'b1, 32'h5555);
        check("empty_pp_cnt", 64'(fifo_count), 64'd1);
        check("empty_pp_dout", 64'(data_out), 64'hBEEF);
        step(1'b1, 1'b0, 1'b1, '0);

        // Wrap-around at low occupancy.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, (i % 3) != 0 || model_q.size() >= 3, DW'(32'hA0 + i));
        end
        while (model_q.size() > 0) step(1'b1, 1'b0, 1'b1, '0);

        // Reset mid-operation with 5 entries stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, DW'(32'h300 + i));
        step(1'b0, 1'b1, 1'b1, 32'hDEAD);
        check("rst_mid_cnt", 64'(fifo_count), 64'd0);
        check("rst_mid_dout", 64'(data_out), 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'hCAFE);
        step(1'b1, 1'b0, 1'b1, '0);
        check("rst_mid_newdata", 64'(data_out), 64'hCAFE);

        // Random traffic in phases of differing push/pop bias.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
                step(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                     $urandom_range(99) < pw,
                     $urandom_range(99) < (100 - pw),
                     $urandom());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
